// File: rtl/elixirchip_es1_spu_op_logic.sv
// elixirchip_es1_spu_op_logic
// N-operand bitwise logic unit: AND / OR / XOR / PASS(operand 0), with an
// optional result inversion and a clear-to-constant override. The result is
// delivered after LATENCY clock-enabled cycles (LATENCY=0: purely combinational).
// The output data register holds its value whenever the emerging token is invalid.
//
// Optional feature macro: ELIXIRCHIP_ES1_SPU_OP_LOGIC_INVERT_EN
//   defined   : s_op[2] inverts the result
//   undefined : s_op[2] is ignored and no inverter is built
module elixirchip_es1_spu_op_logic #(
    parameter int                   LATENCY    = 1,
    parameter int                   NUM_INPUTS = 2,
    parameter int                   DATA_BITS  = 8,
    parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0,
    parameter string                DEVICE     = "RTL",
    parameter string                SIMULATION = "false",
    parameter string                DEBUG      = "false"
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cke,
    input  logic [NUM_INPUTS*DATA_BITS-1:0] s_data,
    input  logic [2:0]                      s_op,
    input  logic                            s_clear,
    input  logic                            s_valid,
    output logic [DATA_BITS-1:0]            m_data,
    output logic                            m_valid
);

    // Informational strings only; they do not alter the generated logic.
    localparam bit cfg_unused = (DEVICE == "") && (SIMULATION == "") && (DEBUG == "");

    // Bitwise reduction of all operands with the selected function.
    function automatic logic [DATA_BITS-1:0] reduce_op(
        input logic [NUM_INPUTS*DATA_BITS-1:0] din,
        input logic [1:0]                      fn
    );
        logic [DATA_BITS-1:0] acc;
        acc = din[0 +: DATA_BITS];
        for (int i = 1; i < NUM_INPUTS; i++) begin
            case (fn)
                2'd0:    acc = acc & din[i*DATA_BITS +: DATA_BITS];
                2'd1:    acc = acc | din[i*DATA_BITS +: DATA_BITS];
                2'd2:    acc = acc ^ din[i*DATA_BITS +: DATA_BITS];
                default: acc = acc;
            endcase
        end
        return acc;
    endfunction

    logic                 invert;
    logic [DATA_BITS-1:0] res_d;

`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_INVERT_EN
    assign invert = s_op[2];
`else
    logic op2_unused;
    assign op2_unused = s_op[2];
    assign invert     = 1'b0;
`endif

    // Token result: reduction, then optional inversion, with clear overriding both.
    always_comb begin
        res_d = reduce_op(s_data, s_op[1:0]);
        if (invert) begin
            res_d = ~res_d;
        end
        if (s_clear) begin
            res_d = CLEAR_DATA;
        end
    end

    generate
        if (LATENCY == 0) begin : g_comb
            // Purely combinational: no registers, so clk/reset/cke play no part.
            logic ctrl_unused;
            assign ctrl_unused = clk ^ reset ^ cke;
            assign m_data      = res_d;
            assign m_valid     = s_valid;
        end else begin : g_pipe
            logic [DATA_BITS-1:0] data_q [LATENCY];
            logic [LATENCY-1:0]   vld_q;

            // Pipeline shift; each stage takes new data only for a valid token,
            // so the last stage naturally holds on invalid tokens.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        data_q[i] <= CLEAR_DATA;
                    end
                end else if (cke) begin
                    // stage 0: capture the computed token result
                    vld_q[0] <= s_valid;
                    if (s_valid) begin
                        data_q[0] <= res_d;
                    end
                    // stages 1..LATENCY-1: carry the token forward
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        if (vld_q[i-1]) begin
                            data_q[i] <= data_q[i-1];
                        end
                    end
                end
            end

            assign m_data  = data_q[LATENCY-1];
            assign m_valid = vld_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_logic.sv
// Testbench for elixirchip_es1_spu_op_logic.
// A main instance (LATENCY=3, NUM_INPUTS=3, DATA_BITS=8, CLEAR_DATA=7b) gets
// directed scenarios with literal expectations plus random traffic; several
// further instances cover other LATENCY/NUM_INPUTS/DATA_BITS corners with
// random traffic. All are compared against a token-queue reference model.
module tb_elixirchip_es1_spu_op_logic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          v;
        logic [63:0] r;
    } tok_t;

    // Expected token result from the functional rules.
    function automatic logic [63:0] ref_r(input logic [511:0] d, input int n, input int w,
                                         input logic [2:0] op, input bit clr,
                                         input logic [63:0] cd);
        logic [63:0] mask, acc, x;
        bit inv;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (clr) return cd & mask;
        acc = (op[1:0] == 2'd0) ? mask : 64'd0;
        for (int i = 0; i < n; i++) begin
            x = 64'(d >> (i * w)) & mask;
            case (op[1:0])
                2'd0:    acc = acc & x;
                2'd1:    acc = acc | x;
                2'd2:    acc = acc ^ x;
                default: if (i == 0) acc = x;
            endcase
        end
        inv = 1'b0;
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_INVERT_EN
        inv = op[2];
`endif
        if (inv) acc = ~acc & mask;
        return acc;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- main instance ----------------
    logic        reset, cke, s_clear, s_valid;
    logic [2:0]  s_op;
    logic [23:0] s_data;
    logic [7:0]  m_data;
    logic        m_valid;

    elixirchip_es1_spu_op_logic #(
        .LATENCY(3), .NUM_INPUTS(3), .DATA_BITS(8), .CLEAR_DATA(8'h7b),
        .DEVICE("RTL"), .SIMULATION("false"), .DEBUG("false")
    ) dut (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_op(s_op),
        .s_clear(s_clear), .s_valid(s_valid), .m_data(m_data), .m_valid(m_valid)
    );

`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_INVERT_EN
    localparam logic [7:0] NOR_EXP  = 8'hf8;
    localparam logic [7:0] XNOR_EXP = 8'hff;
`else
    localparam logic [7:0] NOR_EXP  = 8'h07;
    localparam logic [7:0] XNOR_EXP = 8'h00;
`endif

    tok_t       mq[$];
    tok_t       mt;
    bit         mev = 1'b0;
    logic [7:0] med = 8'h7b;
    bit         mchk = 1'b0;

    // Model: each enabled edge queues one token; the token LATENCY edges old emerges.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mev = 1'b0;
            med = 8'h7b;
        end else if (cke) begin
            mt.v = s_valid;
            mt.r = ref_r(512'(s_data), 3, 8, s_op, s_clear, 64'h7b);
            mq.push_back(mt);
            if (mq.size() == 3) begin
                mt  = mq.pop_front();
                mev = mt.v;
                if (mt.v) med = mt.r[7:0];
            end
        end
    end

    always @(negedge clk) begin
        if (mchk) begin
            chk("main_valid", 64'(m_valid), 64'(mev));
            chk("main_data", 64'(m_data), 64'(med));
        end
    end

    task automatic step(input logic [23:0] d, input logic [2:0] op, input bit clr,
                        input bit v, input bit ck);
        s_data  = d;
        s_op    = op;
        s_clear = clr;
        s_valid = v;
        cke     = ck;
        @(posedge clk);
        #1;
    endtask

    task automatic op_test(input string nm, input logic [23:0] d, input logic [2:0] op,
                           input logic [7:0] exp);
        step(d, op, 1'b0, 1'b1, 1'b1);
        step(24'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(24'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk({nm, "_data"}, 64'(m_data), 64'(exp));
        chk({nm, "_valid"}, 64'(m_valid), 64'd1);
    endtask

    // ---------------- sweep instances ----------------
    localparam int NCFG = 6;
    localparam logic [63:0] CLR_PAT = 64'ha5c3_5a3c_96e1_0f78;

    function automatic int cfg_l(input int g);
        case (g) 0: return 0; 1: return 1; 2: return 2; 3: return 4; 4: return 3; default: return 0; endcase
    endfunction
    function automatic int cfg_n(input int g);
        case (g) 0: return 2; 1: return 8; 2: return 5; 3: return 7; 4: return 4; default: return 6; endcase
    endfunction
    function automatic int cfg_d(input int g);
        case (g) 0: return 1; 1: return 16; 2: return 5; 3: return 13; 4: return 8; default: return 16; endcase
    endfunction

    logic [NCFG-1:0] sw_done;

    for (genvar g = 0; g < NCFG; g++) begin : g_sw
        localparam int L = cfg_l(g);
        localparam int N = cfg_n(g);
        localparam int D = cfg_d(g);
        localparam logic [D-1:0] CD = CLR_PAT[D-1:0];

        logic           rst_s, cke_s, clr_s, vld_s, mv;
        logic [2:0]     op_s;
        logic [N*D-1:0] dat_s;
        logic [D-1:0]   md;
        bit             on = 1'b0;

        elixirchip_es1_spu_op_logic #(
            .LATENCY(L), .NUM_INPUTS(N), .DATA_BITS(D), .CLEAR_DATA(CD),
            .DEVICE("RTL"), .SIMULATION("false"), .DEBUG("false")
        ) dut_sw (
            .clk(clk), .reset(rst_s), .cke(cke_s), .s_data(dat_s), .s_op(op_s),
            .s_clear(clr_s), .s_valid(vld_s), .m_data(md), .m_valid(mv)
        );

        initial begin
            sw_done[g] = 1'b0;
            rst_s = 1'b1; cke_s = 1'b1; clr_s = 1'b0; vld_s = 1'b0; op_s = 3'd0; dat_s = '0;
            repeat (2) @(posedge clk);
            #1;
            rst_s = 1'b0;
            on    = 1'b1;
            for (int c = 0; c < 500; c++) begin
                for (int b = 0; b < N * D; b++) dat_s[b] = 1'($urandom_range(0, 1));
                rst_s = ($urandom_range(0, 63) == 0);
                cke_s = ($urandom_range(0, 3) != 0);
                vld_s = ($urandom_range(0, 1) == 1);
                clr_s = ($urandom_range(0, 7) == 0);
                op_s  = 3'($urandom_range(0, 7));
                @(posedge clk);
                #1;
            end
            sw_done[g] = 1'b1;
        end

        if (L == 0) begin : g_l0
            logic [63:0] exp0;
            always @(negedge clk) begin
                if (on) begin
                    exp0 = ref_r(512'(dat_s), N, D, op_s, clr_s, 64'(CD));
                    chk($sformatf("sw%0d_valid", g), 64'(mv), 64'(vld_s));
                    chk($sformatf("sw%0d_data", g), 64'(md), exp0);
                end
            end
        end else begin : g_lx
            tok_t        q[$];
            tok_t        t;
            bit          ev = 1'b0;
            logic [63:0] ed = 64'(CD);

            always @(posedge clk) begin
                if (rst_s) begin
                    q.delete();
                    ev = 1'b0;
                    ed = 64'(CD);
                end else if (cke_s) begin
                    t.v = vld_s;
                    t.r = ref_r(512'(dat_s), N, D, op_s, clr_s, 64'(CD));
                    q.push_back(t);
                    if (q.size() == L) begin
                        t  = q.pop_front();
                        ev = t.v;
                        if (t.v) ed = t.r;
                    end
                end
            end

            always @(negedge clk) begin
                if (on) begin
                    chk($sformatf("sw%0d_valid", g), 64'(mv), 64'(ev));
                    chk($sformatf("sw%0d_data", g), 64'(md), ed);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; cke = 1'b1; s_data = '0; s_op = 3'd0; s_clear = 1'b0; s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mchk  = 1'b1;
        chk("reset_data", 64'(m_data), 64'h7b);
        chk("reset_valid", 64'(m_valid), 64'd0);

        op_test("and",  {8'h3c, 8'h0f, 8'hff}, 3'd0, 8'h0c);
        op_test("or",   {8'h04, 8'h02, 8'h01}, 3'd1, 8'h07);
        op_test("nor",  {8'h04, 8'h02, 8'h01}, 3'd5, NOR_EXP);
        op_test("xor",  {8'hff, 8'ha5, 8'h5a}, 3'd2, 8'h00);
        op_test("xnor", {8'hff, 8'ha5, 8'h5a}, 3'd6, XNOR_EXP);
        op_test("pass", {8'h00, 8'h00, 8'h99}, 3'd3, 8'h99);

        // clock-enable stall of two cycles between tokens
        step({8'h00, 8'h34, 8'h12}, 3'd2, 1'b0, 1'b1, 1'b1);
        step({8'hff, 8'hff, 8'hff}, 3'd1, 1'b0, 1'b1, 1'b0);
        step({8'hee, 8'hee, 8'hee}, 3'd0, 1'b0, 1'b1, 1'b0);
        step(24'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("stall_hold_valid", 64'(m_valid), 64'd0);
        chk("stall_hold_data", 64'(m_data), 64'h99);
        step(24'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("stall_tok_data", 64'(m_data), 64'h26);
        chk("stall_tok_valid", 64'(m_valid), 64'd1);

        // clear token followed by an invalid clear
        step({8'h99, 8'h99, 8'h99}, 3'd0, 1'b1, 1'b1, 1'b1);
        step(24'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        step(24'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("clear_data", 64'(m_data), 64'h7b);
        chk("clear_valid", 64'(m_valid), 64'd1);
        step(24'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("clear_hold_data", 64'(m_data), 64'h7b);
        chk("clear_hold_valid", 64'(m_valid), 64'd0);

        // reset with two tokens in flight
        step({8'h00, 8'h00, 8'h80}, 3'd1, 1'b0, 1'b1, 1'b1);
        step({8'h00, 8'h00, 8'h01}, 3'd2, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        step(24'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(24'h0, 3'd0, 1'b0, 1'b0, 1'b1);
            chk("flush_valid", 64'(m_valid), 64'd0);
            chk("flush_data", 64'(m_data), 64'h7b);
        end

        // random traffic on the main instance
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            step(24'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0));
        end
        reset = 1'b0;

        for (int i = 0; i < 1000 && sw_done != '1; i++) @(posedge clk);
        chk("sweep_finished", 64'(sw_done), 64'((1 << NCFG) - 1));

        mchk = 1'b0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
